// File: rtl/fire_request_arbiter.sv
// fire_request_arbiter
// Round-robin owner of the shared weapons control unit. One station at a
// time is granted. It receives a single fire_command cycle, then waits for the
// launch strobe, lock loss or timeout. After a launch, a cooldown gap follows
// before the next grant.
module fire_request_arbiter #(
  parameter int N_REQ    = 4,
  parameter int TIMEOUT  = 8,
  parameter int COOLDOWN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             target_locked,
  input  logic             launch_missile,
  input  logic [3:0]       remaining_missiles,
  output logic             fire_command,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] fire_done,
  output logic [N_REQ-1:0] fire_abort,
  output logic             busy,
  output logic [1:0]       sched_state
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(COOLDOWN + 1);

  localparam logic [PW:0]      N_REQ_W   = (PW+1)'(N_REQ);
  localparam logic [PW-1:0]    PTR_LAST  = PW'(N_REQ - 1);
  localparam logic [TW-1:0]    WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0]    COOL_LAST = CW'(COOLDOWN - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FIRE = 2'b01,
    ST_WAIT = 2'b10,
    ST_COOL = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [CW-1:0]    cool_q, cool_d;
  logic             fire_command_q, fire_command_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] fire_done_q, fire_done_d;
  logic [N_REQ-1:0] fire_abort_q, fire_abort_d;
  logic             busy_q, busy_d;

  logic [PW-1:0]    win_idx_s;
  logic             win_valid_s;
  logic [PW:0]      scan_sum_s;
  logic [PW:0]      scan_pos_s;
  logic             scan_hit_s;

  // Pointer step with wrap from the last station back to station 0.
  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
    logic [PW-1:0] nxt;
    if (idx == PTR_LAST) begin
      nxt = '0;
    end else begin
      nxt = idx + PW'(1);
    end
    return nxt;
  endfunction

  // Winner search: first asserted request at or after ptr, wrapping around.
  // Scanning from the far end lets the nearest hit overwrite the others.
  always_comb begin
    win_idx_s   = '0;
    win_valid_s = 1'b0;
    scan_sum_s  = '0;
    scan_pos_s  = '0;
    scan_hit_s  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_sum_s  = {1'b0, ptr_q} + (PW+1)'(i);
      scan_pos_s  = (scan_sum_s >= N_REQ_W) ? (scan_sum_s - N_REQ_W) : scan_sum_s;
      scan_hit_s  = req[scan_pos_s[PW-1:0]];
      win_idx_s   = scan_hit_s ? scan_pos_s[PW-1:0] : win_idx_s;
      win_valid_s = win_valid_s | scan_hit_s;
    end
  end

  // Scheduler next state and next registered outputs; pulses default low.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    wait_d         = wait_q;
    cool_d         = cool_q;
    grant_d        = grant_q;
    fire_command_d = 1'b0;
    fire_done_d    = '0;
    fire_abort_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          if (remaining_missiles == 4'd0) begin
            fire_abort_d = ONE_HOT0 << win_idx_s;
            ptr_d        = ptr_after(win_idx_s);
          end else if (target_locked) begin
            grant_d        = ONE_HOT0 << win_idx_s;
            owner_d        = win_idx_s;
            fire_command_d = 1'b1;
            wait_d         = '0;
            state_d        = ST_FIRE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FIRE: begin
        // The fire_command cycle counts as the first timeout cycle, so the
        // abort lands TIMEOUT edges after the grant.
        wait_d  = TW'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (launch_missile) begin
          fire_done_d = ONE_HOT0 << owner_q;
          grant_d     = '0;
          ptr_d       = ptr_after(owner_q);
          cool_d      = '0;
          state_d     = ST_COOL;
        end else if (!target_locked || (wait_q == WAIT_LAST)) begin
          fire_abort_d = ONE_HOT0 << owner_q;
          grant_d      = '0;
          ptr_d        = ptr_after(owner_q);
          state_d      = ST_IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      ST_COOL: begin
        if (cool_q == COOL_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cool_d = cool_q + CW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, pointer, timers and registered outputs; reset clears all at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      owner_q        <= '0;
      wait_q         <= '0;
      cool_q         <= '0;
      fire_command_q <= 1'b0;
      grant_q        <= '0;
      fire_done_q    <= '0;
      fire_abort_q   <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      owner_q        <= owner_d;
      wait_q         <= wait_d;
      cool_q         <= cool_d;
      fire_command_q <= fire_command_d;
      grant_q        <= grant_d;
      fire_done_q    <= fire_done_d;
      fire_abort_q   <= fire_abort_d;
      busy_q         <= busy_d;
    end
  end

  assign fire_command = fire_command_q;
  assign grant        = grant_q;
  assign fire_done    = fire_done_q;
  assign fire_abort   = fire_abort_q;
  assign busy         = busy_q;
  assign sched_state  = state_q;

endmodule
